// File: rtl/insn_queue_pkg.sv
// Shared fetch-side types and constants for the instruction queue.
package fetch_pkg;

  localparam int          PC_W     = 32;
  localparam int          INSN_W   = 32;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  localparam logic [31:0] BASEADDR = 32'h01000000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } insn_entry_t;

endpackage

// File: rtl/insn_queue_if.sv
// Fetch/decode handshake bundle; master is the fetch+decode side, slave is the queue.
interface insn_queue_if
  import fetch_pkg::*;
#(
  parameter int DWIDTH = INSN_W,
  parameter int AWIDTH = PC_W,
  parameter int DEPTH  = 2
);
  logic                         enq_valid_i;
  logic [AWIDTH-1:0]            enq_pc_i;
  logic [DWIDTH-1:0]            enq_insn_i;
  logic                         enq_ready_o;
  logic                         flush_i;
  logic                         deq_valid_o;
  logic [AWIDTH-1:0]            deq_pc_o;
  logic [DWIDTH-1:0]            deq_insn_o;
  logic                         deq_ready_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output enq_valid_i, enq_pc_i, enq_insn_i, flush_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_insn_o, count_o
  );

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_insn_i, flush_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_insn_o, count_o
  );
endinterface

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction FIFO with flush; registered-only enq_ready, no empty bypass.
module insn_queue
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = INSN_W,
  parameter int                AWIDTH   = PC_W,
  parameter int                DEPTH    = 2,
  parameter logic [DWIDTH-1:0] NOP_INSN = fetch_pkg::NOP_INSN
) (
  input logic         clk,
  input logic         rst,
  insn_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign q.enq_ready_o = (count != CW'(DEPTH));
  assign q.deq_valid_o = (count != '0);
  assign q.count_o     = count;
  assign push          = q.enq_valid_i & q.enq_ready_o;
  assign pop           = q.deq_valid_o & q.deq_ready_i;

  always_comb begin
    q.deq_pc_o   = '0;
    q.deq_insn_o = NOP_INSN;
    if (q.deq_valid_o) begin
      q.deq_pc_o   = mem[rd_ptr].pc;
      q.deq_insn_o = mem[rd_ptr].insn;
    end
  end

  // Storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !q.flush_i) begin
      mem[wr_ptr] <= '{pc: q.enq_pc_i, insn: q.enq_insn_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
